// File: rtl/alu_pkg.sv
// Shared ALU control codes, legality check, arbiter FSM states and response record.
package alu_pkg;

  localparam logic [6:0] AluAdd  = 7'h1C;
  localparam logic [6:0] AluSub  = 7'h1D;
  localparam logic [6:0] AluSll  = 7'h1E;
  localparam logic [6:0] AluSlt  = 7'h1F;
  localparam logic [6:0] AluSltu = 7'h20;
  localparam logic [6:0] AluXor  = 7'h21;
  localparam logic [6:0] AluSrl  = 7'h22;
  localparam logic [6:0] AluSra  = 7'h23;
  localparam logic [6:0] AluOr   = 7'h24;
  localparam logic [6:0] AluAnd  = 7'h25;

  // Wide enough for the largest supported requester count (8).
  localparam int unsigned MaxIdW = 3;

  // Legal codes form one contiguous range.
  function automatic logic is_legal_op(logic [6:0] op);
    return (op >= AluAdd) && (op <= AluAnd);
  endfunction

  typedef enum logic [1:0] {
    StIdle,
    StExec,
    StResp
  } state_e;

  typedef struct packed {
    logic [MaxIdW-1:0] id;
    logic [31:0]       result;
    logic              zero;
    logic              overflow;
    logic              negative;
    logic              err;
  } rsp_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request, ALU and response channels of the shared-ALU arbiter.
interface alu_arbiter_if #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [NUM_REQ*32-1:0] req_a;
  logic [NUM_REQ*32-1:0] req_b;
  logic [NUM_REQ*7-1:0]  req_op;

  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [6:0]  alu_ctrl;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic        alu_overflow;
  logic        alu_negative;

  logic            rsp_valid;
  logic            rsp_ready;
  logic [ID_W-1:0] rsp_id;
  logic [31:0]     rsp_result;
  logic            rsp_zero;
  logic            rsp_overflow;
  logic            rsp_negative;
  logic            rsp_err;

  // Requesters, ALU and response consumer together.
  modport master (
    output req_valid, req_a, req_b, req_op,
    input  req_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_zero, alu_overflow, alu_negative,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_negative, rsp_err,
    output rsp_ready
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op,
    output req_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_zero, alu_overflow, alu_negative,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_overflow, rsp_negative, rsp_err,
    input  rsp_ready
  );

endinterface

// File: rtl/rr_picker.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module rr_picker #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    idx,
  output logic               any
);

  logic [ID_W-1:0] cand;

  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ID_W'((int'(ptr) + i) % NUM_REQ);
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = cand;
      end
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU; one operation in flight at a time.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input logic         clk,
  input logic         rst,
  alu_arbiter_if.slave bus
);

  state_e state_q, state_d;

  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_next;
  logic [NUM_REQ-1:0] grant;
  logic [ID_W-1:0]    grant_idx;
  logic               grant_any;
  logic               accept;

  logic [31:0] alu_a_q, alu_b_q;
  logic [6:0]  alu_ctrl_q;
  rsp_t        rsp_q;

  logic [31:0] a_arr  [NUM_REQ];
  logic [31:0] b_arr  [NUM_REQ];
  logic [6:0]  op_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i]  = bus.req_a[32*i +: 32];
    assign b_arr[i]  = bus.req_b[32*i +: 32];
    assign op_arr[i] = bus.req_op[7*i +: 7];
  end

  rr_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_picker (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_q),
    .grant (grant),
    .idx   (grant_idx),
    .any   (grant_any)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      StIdle: begin
        // No grant while reset is held, even though the FSM already sits in idle.
        if (grant_any && !rst) begin
          accept  = 1'b1;
          state_d = StExec;
        end
      end
      StExec:  state_d = StResp;
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign rr_ptr_next = (int'(grant_idx) == NUM_REQ - 1) ? '0 : grant_idx + ID_W'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      rr_ptr_q   <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_ctrl_q <= AluAdd;
      rsp_q      <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        alu_a_q    <= a_arr[grant_idx];
        alu_b_q    <= b_arr[grant_idx];
        alu_ctrl_q <= op_arr[grant_idx];
        rsp_q.id   <= MaxIdW'(grant_idx);
        rr_ptr_q   <= rr_ptr_next;
      end
      if (state_q == StExec) begin
        rsp_q.result   <= bus.alu_result;
        rsp_q.zero     <= bus.alu_zero;
        rsp_q.overflow <= bus.alu_overflow;
        rsp_q.negative <= bus.alu_negative;
        rsp_q.err      <= !is_legal_op(alu_ctrl_q);
      end
    end
  end

  assign bus.req_ready    = accept ? grant : '0;
  assign bus.alu_a        = alu_a_q;
  assign bus.alu_b        = alu_b_q;
  assign bus.alu_ctrl     = alu_ctrl_q;
  assign bus.rsp_valid    = (state_q == StResp);
  assign bus.rsp_id       = ID_W'(rsp_q.id);
  assign bus.rsp_result   = rsp_q.result;
  assign bus.rsp_zero     = rsp_q.zero;
  assign bus.rsp_overflow = rsp_q.overflow;
  assign bus.rsp_negative = rsp_q.negative;
  assign bus.rsp_err      = rsp_q.err;

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter with a transaction-level round-robin reference model.
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int N   = 3;
  localparam int IdW = $clog2(N);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  alu_arbiter_if #(.NUM_REQ(N), .ID_W(IdW)) bus ();

  alu_arbiter #(
    .NUM_REQ (N),
    .ID_W    (IdW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int ptr      = 0;

  logic [31:0] ma  [N];
  logic [31:0] mb  [N];
  logic [6:0]  mop [N];

  for (genvar i = 0; i < N; i++) begin : g_pack
    assign bus.req_a[32*i +: 32] = ma[i];
    assign bus.req_b[32*i +: 32] = mb[i];
    assign bus.req_op[7*i +: 7]  = mop[i];
  end

  function automatic logic [31:0] alu_fn(logic [6:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      AluAdd:  return a + b;
      AluSub:  return a - b;
      AluSll:  return a << b[4:0];
      AluSlt:  return {31'b0, $signed(a) < $signed(b)};
      AluSltu: return {31'b0, a < b};
      AluXor:  return a ^ b;
      AluSrl:  return a >> b[4:0];
      AluSra:  return 32'($signed(a) >>> b[4:0]);
      AluOr:   return a | b;
      AluAnd:  return a & b;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic alu_ovf(logic [6:0] op, logic [31:0] a, logic [31:0] b);
    logic [31:0] r;
    r = alu_fn(op, a, b);
    if (op == AluAdd) return (a[31] == b[31]) && (r[31] != a[31]);
    if (op == AluSub) return (a[31] != b[31]) && (r[31] != a[31]);
    return 1'b0;
  endfunction

  // Stand-in for the real ALU wired between alu_* outputs and inputs.
  always_comb begin
    bus.alu_result   = alu_fn(bus.alu_ctrl, bus.alu_a, bus.alu_b);
    bus.alu_zero     = (bus.alu_result == 32'h0);
    bus.alu_negative = bus.alu_result[31];
    bus.alu_overflow = alu_ovf(bus.alu_ctrl, bus.alu_a, bus.alu_b);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [6:0] rand_op();
    if ($urandom_range(0, 3) == 0) return 7'($urandom);
    return AluAdd + 7'($urandom_range(0, 9));
  endfunction

  task automatic randomize_reqs();
    for (int i = 0; i < N; i++) begin
      ma[i]  = $urandom;
      mb[i]  = ($urandom_range(0, 4) == 0) ? ma[i] : $urandom;
      mop[i] = rand_op();
    end
  endtask

  task automatic check_rsp(input int g, input logic [31:0] r, input logic ov, input logic e);
    check("rsp_valid", 32'(bus.rsp_valid), 32'd1);
    check("rsp_id", 32'(bus.rsp_id), 32'(g));
    check("rsp_result", bus.rsp_result, r);
    check("rsp_zero", 32'(bus.rsp_zero), 32'(r == 32'h0));
    check("rsp_negative", 32'(bus.rsp_negative), 32'(r[31]));
    check("rsp_overflow", 32'(bus.rsp_overflow), 32'(ov));
    check("rsp_err", 32'(bus.rsp_err), 32'(e));
  endtask

  // One full transaction from idle; hold = cycles of response backpressure.
  task automatic do_txn(input logic [N-1:0] mask, input int hold);
    int g;
    logic [31:0] r;
    logic ov, e;
    g = -1;
    for (int k = 0; k < N; k++) begin
      if (g < 0 && mask[(ptr + k) % N]) g = (ptr + k) % N;
    end
    r  = alu_fn(mop[g], ma[g], mb[g]);
    ov = alu_ovf(mop[g], ma[g], mb[g]);
    e  = !(mop[g] inside {[7'h1C:7'h25]});
    bus.req_valid = mask;
    #1;
    check("grant", 32'(bus.req_ready), 32'(1) << g);
    @(posedge clk); #1;
    ptr = (g + 1) % N;
    check("exec_ready", 32'(bus.req_ready), 32'd0);
    check("exec_valid", 32'(bus.rsp_valid), 32'd0);
    check("alu_a", bus.alu_a, ma[g]);
    check("alu_b", bus.alu_b, mb[g]);
    check("alu_ctrl", 32'(bus.alu_ctrl), 32'(mop[g]));
    @(posedge clk); #1;
    bus.rsp_ready = (hold == 0);
    check_rsp(g, r, ov, e);
    for (int c = 0; c < hold; c++) begin
      @(posedge clk); #1;
      if (c == hold - 1) bus.rsp_ready = 1'b1;
      check("bp_ready", 32'(bus.req_ready), 32'd0);
      check_rsp(g, r, ov, e);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    bus.req_valid = '0;
    check("done_valid", 32'(bus.rsp_valid), 32'd0);
  endtask

  initial begin
    randomize_reqs();
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(bus.req_ready), 32'd0);
    check("rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_alu_b", bus.alu_b, 32'd0);
    check("rst_ctrl", 32'(bus.alu_ctrl), 32'h1C);
    check("rst_id", 32'(bus.rsp_id), 32'd0);
    check("rst_result", bus.rsp_result, 32'd0);
    check("rst_flags", 32'({bus.rsp_zero, bus.rsp_overflow, bus.rsp_negative, bus.rsp_err}), 32'd0);
    rst = 1'b0;
    bus.req_valid = '0;

    // Single ADD 5+7 from requester 0.
    randomize_reqs();
    ma[0] = 32'd5; mb[0] = 32'd7; mop[0] = AluAdd;
    do_txn(3'b001, 0);

    // Requesters 0 and 1 continuously valid: grants alternate.
    for (int t = 0; t < 4; t++) begin
      randomize_reqs();
      do_txn(3'b011, 0);
    end

    // SUB 3-3 held back for five cycles.
    randomize_reqs();
    ma[0] = 32'd3; mb[0] = 32'd3; mop[0] = AluSub;
    do_txn(3'b001, 5);

    // Illegal op from requester 1.
    randomize_reqs();
    mop[1] = 7'h00;
    do_txn(3'b010, 0);

    // Reset while in EXEC drops the operation and rewinds the pointer.
    randomize_reqs();
    ptr = 1;
    bus.req_valid = 3'b010;
    #1;
    check("pre_rst_grant", 32'(bus.req_ready), 32'd2);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr = 0;
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    bus.req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      check("dropped_rsp", 32'(bus.rsp_valid), 32'd0);
    end
    randomize_reqs();
    do_txn(3'b111, 0);

    // Pointer wrap with three requesters: 2, then 0, then 2.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    ptr = 0;
    randomize_reqs();
    do_txn(3'b100, 0);
    randomize_reqs();
    do_txn(3'b101, 0);
    randomize_reqs();
    do_txn(3'b101, 0);

    for (int t = 0; t < 40; t++) begin
      logic [N-1:0] m;
      randomize_reqs();
      m = N'($urandom_range(1, (1 << N) - 1));
      do_txn(m, int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
